// File: rtl/spi_object_loader.sv
// Parses the framed object stream from the SPI word deserializer into quad RAM and starts the subdivision engine.
// Optional build macro LOADER_INDEX_CHECK_EN rejects face indices that are >= the vertex count.
module spi_object_loader #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [31:0]           rx_data,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] vertex_count,
    output logic [ADDR_WIDTH-1:0] face_count,
    output logic                  busy,
    output logic                  start_proc,
    output logic                  load_error
);
    localparam int KW = ADDR_WIDTH + 1;
    localparam int CW = 2 * ADDR_WIDTH + 4;
    localparam logic [31:0] MAX_N = 32'(1) << ADDR_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VCOUNT = 3'd1;
    localparam logic [2:0] S_VERTS  = 3'd2;
    localparam logic [2:0] S_FCOUNT = 3'd3;
    localparam logic [2:0] S_FACES  = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    logic [2:0]    state;
    logic [KW-1:0] k;
    logic [KW-1:0] n_words;
    logic [KW-1:0] v_cnt;
    logic          hdr_bad, word_big, vcount_bad, fcount_bad, last_vert, last_obj;
    logic [CW-1:0] v_need, f_need;

    // Any count word with bits above KW already exceeds the largest legal object,
    // so it is flagged directly and the products below never see it.
    assign hdr_bad    = (rx_data < 32'd2) || (rx_data > MAX_N);
    assign word_big   = |rx_data[31:KW];
    assign v_need     = CW'(3) * CW'(rx_data[KW-1:0]) + CW'(2);
    assign f_need     = CW'(3) * (CW'(v_cnt) + CW'(rx_data[KW-1:0])) + CW'(2);
    assign vcount_bad = word_big || (v_need > CW'(n_words));
    assign fcount_bad = word_big || (f_need != CW'(n_words));
    assign last_vert  = CW'(k) == CW'(3) * CW'(v_cnt);
    assign last_obj   = (k + KW'(1)) == n_words;
    assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

`ifdef LOADER_INDEX_CHECK_EN
    logic idx_hit;
    assign idx_hit = rx_data >= 32'(v_cnt);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            k            <= '0;
            n_words      <= '0;
            v_cnt        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            vertex_count <= '0;
            face_count   <= '0;
            start_proc   <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            start_proc <= 1'b0;
            if (rx_valid && busy && state != S_DRAIN) begin
                mem_we    <= 1'b1;
                mem_addr  <= k[ADDR_WIDTH-1:0];
                mem_wdata <= rx_data;
            end
            if (rx_valid && busy)
                k <= k + KW'(1);

            case (state)
                S_IDLE: if (rx_valid) begin
                    k       <= '0;
                    n_words <= rx_data[KW-1:0];
                    if (hdr_bad) begin
                        load_error <= 1'b1;
                        state      <= S_ERROR;
                    end else begin
                        state <= S_VCOUNT;
                    end
                end
                S_VCOUNT: if (rx_valid) begin
                    vertex_count <= rx_data[ADDR_WIDTH-1:0];
                    v_cnt        <= rx_data[KW-1:0];
                    if (vcount_bad) begin
                        load_error <= 1'b1;
                        state      <= S_DRAIN;
                    end else if (rx_data == 32'd0) begin
                        state <= S_FCOUNT;
                    end else begin
                        state <= S_VERTS;
                    end
                end
                S_VERTS: if (rx_valid && last_vert)
                    state <= S_FCOUNT;
                S_FCOUNT: if (rx_valid) begin
                    face_count <= rx_data[ADDR_WIDTH-1:0];
                    if (fcount_bad) begin
                        load_error <= 1'b1;
                        state      <= last_obj ? S_ERROR : S_DRAIN;
                    end else if (rx_data == 32'd0) begin
                        state      <= S_DONE;
                        start_proc <= 1'b1;
                    end else begin
                        state <= S_FACES;
                    end
                end
                S_FACES: if (rx_valid) begin
`ifdef LOADER_INDEX_CHECK_EN
                    // load_error is clear on entry here, so it doubles as the sticky bad-index flag
                    if (idx_hit)
                        load_error <= 1'b1;
                    if (last_obj) begin
                        if (load_error || idx_hit) begin
                            state <= S_ERROR;
                        end else begin
                            state      <= S_DONE;
                            start_proc <= 1'b1;
                        end
                    end
`else
                    if (last_obj) begin
                        state      <= S_DONE;
                        start_proc <= 1'b1;
                    end
`endif
                end
                S_DRAIN: if (rx_valid && last_obj)
                    state <= S_ERROR;
                default: if (restart) begin
                    state      <= S_IDLE;
                    load_error <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_object_loader.sv
// Scoreboard bench for spi_object_loader: expected RAM writes are queued as words are sent and matched as mem_we fires.
module tb_spi_object_loader;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [31:0]   rx_data;
    logic          restart;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] vertex_count;
    logic [AW-1:0] face_count;
    logic          busy;
    logic          start_proc;
    logic          load_error;

    spi_object_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .restart(restart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .vertex_count(vertex_count), .face_count(face_count), .busy(busy),
        .start_proc(start_proc), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] obj[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          we_count = 0;
    int          sp_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(mem_we), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
            end
        end
        if (start_proc === 1'b1) begin
            sp_count++;
            check("start_with_last_we", 64'(mem_we), 64'(1));
            check("start_q_empty", 64'(exp_q.size()), 64'(0));
        end
    end

    function automatic void make_obj(input int v, input int f, input int n_total);
        obj.delete();
        obj.push_back(32'(v));
        for (int i = 0; i < 3 * v && obj.size() < n_total; i++) obj.push_back($urandom);
        if (obj.size() < n_total) obj.push_back(32'(f));
        for (int j = 0; j < 3 * f && obj.size() < n_total; j++) obj.push_back(32'(j % ((v > 0) ? v : 1)));
        while (obj.size() < n_total) obj.push_back($urandom);
    endfunction

    task automatic send_word(input logic [31:0] d, input bit wr, input int addr);
        rx_valid = 1'b1;
        rx_data  = d;
        if (wr) exp_q.push_back('{addr: AW'(addr), data: d});
        @(negedge clk);
    endtask

    task automatic send_obj(input int first, input int last, input int n_wr);
        for (int i = first; i <= last; i++) send_word(obj[i], i < n_wr, i);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_we"}, 64'(mem_we), 64'(0));
        check({pfx, "_addr"}, 64'(mem_addr), 64'(0));
        check({pfx, "_wdata"}, 64'(mem_wdata), 64'(0));
        check({pfx, "_vcount"}, 64'(vertex_count), 64'(0));
        check({pfx, "_fcount"}, 64'(face_count), 64'(0));
        check({pfx, "_busy"}, 64'(busy), 64'(0));
        check({pfx, "_start"}, 64'(start_proc), 64'(0));
        check({pfx, "_err"}, 64'(load_error), 64'(0));
    endtask

    task automatic check_end(input string pfx, input int vc, input int fc, input int sp, input int err, input int wes);
        check({pfx, "_q_empty"}, 64'(exp_q.size()), 64'(0));
        check({pfx, "_vcount"}, 64'(vertex_count), 64'(vc));
        check({pfx, "_fcount"}, 64'(face_count), 64'(fc));
        check({pfx, "_starts"}, 64'(sp_count), 64'(sp));
        check({pfx, "_err"}, 64'(load_error), 64'(err));
        check({pfx, "_busy"}, 64'(busy), 64'(0));
        check({pfx, "_writes"}, 64'(we_count), 64'(wes));
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        restart  = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // Good object, back-to-back words
        make_obj(4, 4, 26);
        send_word(32'd26, 1'b0, 0);
        check("busy_after_hdr", 64'(busy), 64'(1));
        send_obj(0, 25, 26);
        idle(3);
        check_end("good26", 4, 4, 1, 0, 26);

        // Words after DONE are ignored
        repeat (5) send_word(32'hFFFF_FFFF, 1'b0, 0);
        idle(3);
        check_end("after_done", 4, 4, 1, 0, 26);

        // restart together with a word: word is dropped
        rx_valid = 1'b1;
        rx_data  = 32'd26;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("restart_wins_busy", 64'(busy), 64'(0));

        // Face count disagrees with header: drain then ERROR
        make_obj(4, 4, 20);
        send_word(32'd20, 1'b0, 0);
        send_obj(0, 18, 14);
        check("busy_drain", 64'(busy), 64'(1));
        send_obj(19, 19, 14);
        idle(3);
        check_end("mismatch20", 4, 4, 1, 1, 40);
        do_restart();
        check("restart_clr", 64'(load_error), 64'(0));

        // Oversized header
        send_word(32'd4096, 1'b0, 0);
        idle(3);
        check_end("hdr4096", 4, 4, 1, 1, 40);
        do_restart();
        check("restart_clr2", 64'(load_error), 64'(0));

        // Undersized header
        send_word(32'd1, 1'b0, 0);
        idle(2);
        check("hdr1_err", 64'(load_error), 64'(1));
        do_restart();

        // Smallest legal object: V=0, F=0
        make_obj(0, 0, 2);
        send_word(32'd2, 1'b0, 0);
        send_obj(0, 1, 2);
        idle(3);
        check_end("min2", 0, 0, 2, 0, 42);
        do_restart();

        // Vertices only
        make_obj(2, 0, 8);
        send_word(32'd8, 1'b0, 0);
        send_obj(0, 7, 8);
        idle(3);
        check_end("v2f0", 2, 0, 3, 0, 50);
        do_restart();

        // Asynchronous reset after the 7th vertex word
        make_obj(4, 4, 26);
        send_word(32'd26, 1'b0, 0);
        send_obj(0, 7, 8);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_writes", 64'(we_count), 64'(58));
        check("rst_q_empty", 64'(exp_q.size()), 64'(0));

        make_obj(4, 4, 26);
        send_word(32'd26, 1'b0, 0);
        send_obj(0, 25, 26);
        idle(3);
        check_end("reload26", 4, 4, 4, 0, 84);
        do_restart();

        // Face index 7 with only 4 vertices
        make_obj(4, 1, 17);
        obj[14] = 32'd0;
        obj[15] = 32'd1;
        obj[16] = 32'd7;
        send_word(32'd17, 1'b0, 0);
        send_obj(0, 16, 17);
        idle(3);
`ifdef LOADER_INDEX_CHECK_EN
        check_end("bad_index", 4, 1, 4, 1, 101);
`else
        check_end("bad_index", 4, 1, 5, 0, 101);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_object_loader.md
Name: spi_object_loader

Overview:
- Sits directly downstream of the SPI slave word deserializer inside top and upstream of the subdivision engine.
- Consumes the inbound object stream: a header word holding the total word count, then the object words.
- Object word layout: vertex count V, 3V vertex words, face count F, 3F face words.
- Writes object words into the quad RAM, parses V and F, validates framing, and hands off to the engine with a one-cycle start pulse.

Parameters:
- ADDR_WIDTH, 11, quad RAM address width. Maximum object size is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete received SPI word
- rx_data  in  32  received word
- restart  in  1  one-cycle pulse: return from DONE/ERROR to IDLE
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM write address
- mem_wdata  out  32  RAM write data
- vertex_count  out  ADDR_WIDTH  latched V
- face_count  out  ADDR_WIDTH  latched F
- busy  out  1  high in every state except IDLE, DONE, ERROR
- start_proc  out  1  one-cycle pulse to the subdivision engine
- load_error  out  1  sticky framing-error flag

Behaviour:
- Reset: every output is 0, state is IDLE, and the internal counters are 0. Reset can arrive in any state and aborts the load immediately, with no further writes.
- States: IDLE, VCOUNT, VERTS, FCOUNT, FACES, DRAIN, DONE, ERROR. Only cycles with rx_valid=1 advance the state machine. rx_valid may be asserted on consecutive cycles.
- IDLE:
  - On rx_valid, latch declared count N = rx_data and clear the word index k to 0.
  - N < 2 or N > 2**ADDR_WIDTH: go to ERROR.
  - Otherwise go to VCOUNT.
- Object words: every object word in VCOUNT, VERTS, FCOUNT and FACES is written with mem_addr=k and mem_wdata=word. The write is registered: mem_we pulses the cycle after rx_valid. k then increments.
- VCOUNT:
  - Latch V.
  - If 3V+2 > N: set load_error and go to DRAIN. The V word is still written.
  - If V=0: go to FCOUNT.
  - Otherwise go to VERTS.
- VERTS: after 3V words, go to FCOUNT.
- FCOUNT:
  - Latch F.
  - If 3(V+F)+2 != N: set load_error and go to DRAIN.
  - If F=0: go to DONE and pulse start_proc.
  - Otherwise go to FACES.
- FACES: after 3F words, go to DONE and pulse start_proc. The pulse occurs in the same cycle as the final mem_we.
- DRAIN: consume words until N object words have been received in total, with no writes, then go to ERROR.
- DONE and ERROR: further rx_valid words are ignored, with no writes. restart returns to IDLE and clears load_error. restart in any other state is ignored.
- Arithmetic: framing checks are computed at 2*ADDR_WIDTH+4 bits so that 32-bit V and F values cannot wrap. vertex_count and face_count hold the low ADDR_WIDTH bits of the latched values.
- Simultaneous rx_valid and restart in DONE/ERROR: restart wins and the word is dropped.

Optional Feature:
- Macro: LOADER_INDEX_CHECK_EN.
- With the macro defined:
  - Each face word in FACES is compared against V.
  - Any index >= V sets load_error.
  - The offending word is still written, and loading continues to the end of the faces.
  - The FSM ends in ERROR instead of DONE, with no start_proc pulse.
- With the macro undefined: face words are not checked, and the comparator logic is absent.

Test Plan:
- N=26, V=4 (12 vertex words), F=4 (12 face words), sent back-to-back:
  - 26 writes at addresses 0..25 with matching data, each one cycle after its rx_valid.
  - Then vertex_count=4, face_count=4, a single start_proc pulse, load_error=0, busy=0.
- N=20, V=4, F=4 -> FCOUNT mismatch:
  - Words 0..13 are written, no writes after that.
  - After 20 words the FSM is in ERROR with load_error=1 and no start_proc.
- N=4096 with ADDR_WIDTH=11 -> ERROR immediately, with no writes. Then restart clears load_error, and a subsequent valid load succeeds.
- Reset asserted after the 7th vertex word:
  - All outputs go to 0 asynchronously.
  - A fresh N=26 load then completes normally.
- After DONE, 5 extra rx_valid words (for example 0xFFFFFFFF) -> no mem_we, no state change.
- With LOADER_INDEX_CHECK_EN defined: V=4, F=1, face words 0,1,7 -> all 3 written, load_error=1, ERROR state, no start_proc.
